pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch address generator: sequential PC advance with branch/exception redirect,
// a one-deep pending-redirect register and a fetch advance counter.
module pc_gen #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'hbfc00000,
  parameter int                 FETCH_BYTES  = 4,
  parameter int                 STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               imem_ack,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               imem_req,
  output logic               misalign_o,
  output logic [31:0]        fetch_count
);

  // state | meaning
  // IDLE  | first cycle after reset, enables the instruction memory
  // FETCH | request outstanding at pc, waiting for imem_ack
  // HOLD  | fetch at pc completed but PC stage stalled
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(FETCH_BYTES - 1);
  localparam logic [ADDR_W-1:0] FETCH_INC   = ADDR_W'(FETCH_BYTES);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              ce_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
  logic              misalign_nxt;
  logic [31:0]       fetch_count_nxt;
  logic              advance;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              unused_stall;

  // only bit 0 of the stall vector belongs to the PC stage
  assign unused_stall = ^stall;

  assign imem_req      = ce && (state == FETCH);
  assign redirect      = pend_valid || branch_flag_i;
  assign redirect_addr = pend_valid ? pend_addr : branch_target_address_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      ce          <= 1'b0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      misalign_o  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ce          <= ce_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_addr   <= pend_addr_nxt;
      misalign_o  <= misalign_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    ce_nxt          = ce;
    pend_valid_nxt  = pend_valid;
    pend_addr_nxt   = pend_addr;
    misalign_nxt    = 1'b0;
    fetch_count_nxt = fetch_count;
    advance         = 1'b0;

    case (state)
      IDLE: begin
        ce_nxt    = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (stall[0]) state_nxt = HOLD;
          else          advance   = 1'b1;
        end
      end
      HOLD: begin
        if (!stall[0]) begin
          advance   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      if (redirect) begin
        pc_nxt       = redirect_addr & ~OFFSET_MASK;
        misalign_nxt = |(redirect_addr & OFFSET_MASK);
      end else begin
        pc_nxt = pc + FETCH_INC;
      end
      pend_valid_nxt  = 1'b0;
      fetch_count_nxt = fetch_count + 32'd1;
    end else if (branch_flag_i) begin
      pend_valid_nxt = 1'b1;
      pend_addr_nxt  = branch_target_address_i;
    end

    // exception redirect overrides everything once the memory is enabled
    if (flush && ce) begin
      pc_nxt          = new_pc & ~OFFSET_MASK;
      misalign_nxt    = |(new_pc & OFFSET_MASK);
      pend_valid_nxt  = 1'b0;
      state_nxt       = FETCH;
      fetch_count_nxt = fetch_count;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a behavioural fetch-address model.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_ack;
  logic [31:0] pc;
  logic        ce;
  logic        imem_req;
  logic        misalign_o;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // behavioural model: "started" = left the reset cycle, "parked" = fetch done but stalled
  logic [31:0] m_pc, m_pend_addr, m_cnt;
  bit          m_ce, m_started, m_parked, m_pend, m_mis;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
    .imem_ack(imem_ack), .pc(pc), .ce(ce), .imem_req(imem_req),
    .misalign_o(misalign_o), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] down4(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  task automatic step();
    logic [31:0] tgt;
    bit          adv;
    @(posedge clk);
    if (rst) begin
      m_pc = RV; m_ce = 0; m_started = 0; m_parked = 0;
      m_pend = 0; m_pend_addr = 0; m_mis = 0; m_cnt = 0;
    end else if (!m_started) begin
      m_mis = 0; m_ce = 1; m_started = 1; m_parked = 0;
      if (branch_flag_i) begin m_pend = 1; m_pend_addr = branch_target_address_i; end
    end else if (flush) begin
      m_pc = down4(new_pc); m_mis = (new_pc % 4) != 0; m_pend = 0; m_parked = 0;
    end else begin
      m_mis = 0;
      adv = !stall[0] && (m_parked || imem_ack);
      if (adv) begin
        if (m_pend || branch_flag_i) begin
          tgt   = m_pend ? m_pend_addr : branch_target_address_i;
          m_pc  = down4(tgt);
          m_mis = (tgt % 4) != 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
        m_pend = 0; m_parked = 0; m_cnt = m_cnt + 1;
      end else begin
        if (imem_ack && stall[0]) m_parked = 1;
        if (branch_flag_i) begin m_pend = 1; m_pend_addr = branch_target_address_i; end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = '0; flush = 0; new_pc = '0;
    branch_flag_i = 0; branch_target_address_i = '0; imem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; flush = 1; new_pc = 32'h12345678;
    branch_flag_i = 1; branch_target_address_i = 32'h80000000;
    step(); step();
    checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", ce); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misalign_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hbfc00000; exp_pc[1] = 32'hbfc00004; exp_pc[2] = 32'hbfc00008;
    idle_inputs(); rst = 1; step();
    rst = 0; imem_ack = 1;
    step();
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL seq_ce: got %b want 1", ce); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b want 1", imem_req); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc[i]); end
    end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL seq_count: got %0d want 2", fetch_count); end
  endtask

  task automatic test_branch_hold();
    step(); step();
    checks++; if (pc !== 32'hbfc00010) begin errors++; $display("FAIL bh_start: got %h want bfc00010", pc); end
    stall = 6'h01; branch_flag_i = 1; branch_target_address_i = 32'h80001000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'hbfc00010) begin errors++; $display("FAIL bh_hold%0d: got %h want bfc00010", i, pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bh_req%0d: got %b want 0", i, imem_req); end
    end
    stall = '0; branch_flag_i = 0; branch_target_address_i = '0;
    step();
    checks++; if (pc !== 32'h80001000) begin errors++; $display("FAIL bh_target: got %h want 80001000", pc); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL bh_count: got %0d want 5", fetch_count); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bh_req_back: got %b want 1", imem_req); end
  endtask

  task automatic test_flush();
    imem_ack = 0; stall = 6'h01; branch_flag_i = 1; branch_target_address_i = 32'h80002000;
    step();
    checks++; if (pc !== 32'h80001000) begin errors++; $display("FAIL fl_nochange: got %h want 80001000", pc); end
    branch_flag_i = 0; flush = 1; new_pc = 32'hbfc00380;
    step();
    checks++; if (pc !== 32'hbfc00380) begin errors++; $display("FAIL fl_pc: got %h want bfc00380", pc); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL fl_count: got %0d want 5", fetch_count); end
    flush = 0; imem_ack = 1; stall = '0;
    step();
    checks++; if (pc !== 32'hbfc00384) begin errors++; $display("FAIL fl_pend_cleared: got %h want bfc00384", pc); end
  endtask

  task automatic test_misalign();
    branch_flag_i = 1; branch_target_address_i = 32'h80000006;
    step();
    checks++; if (pc !== 32'h80000004) begin errors++; $display("FAIL mis_pc: got %h want 80000004", pc); end
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misalign_o); end
    branch_flag_i = 0;
    step();
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misalign_o); end
    checks++; if (pc !== 32'h80000008) begin errors++; $display("FAIL mis_next: got %h want 80000008", pc); end
  endtask

  task automatic test_wrap();
    imem_ack = 0; flush = 1; new_pc = 32'hfffffffc;
    step();
    checks++; if (pc !== 32'hfffffffc) begin errors++; $display("FAIL wrap_load: got %h want fffffffc", pc); end
    flush = 0; imem_ack = 1;
    step();
    checks++; if (pc !== 32'h00000000) begin errors++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
  endtask

  task automatic test_reset_priority();
    imem_ack = 1; stall = 6'h01; branch_flag_i = 1; branch_target_address_i = 32'h80003000;
    step();
    rst = 1; flush = 1; new_pc = 32'h00001000;
    step();
    checks++; if (pc !== RV) begin errors++; $display("FAIL rp_pc: got %h want %h", pc, RV); end
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rp_ce: got %b want 0", ce); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rp_req: got %b want 0", imem_req); end
    rst = 0; branch_flag_i = 0;
    step();
    checks++; if (pc !== RV) begin errors++; $display("FAIL rp_idle_flush: got %h want %h", pc, RV); end
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL rp_idle_ce: got %b want 1", ce); end
    flush = 0; stall = 6'h3e;
    step();
    checks++; if (pc !== RV + 32'd4) begin errors++; $display("FAIL rp_upper_stall: got %h want %h", pc, RV + 32'd4); end
  endtask

  task automatic test_random();
    idle_inputs(); rst = 1; step();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(99) < 2);
      stall         = 6'($urandom);
      stall[0]      = ($urandom_range(99) < 35);
      flush         = ($urandom_range(99) < 6);
      new_pc        = $urandom;
      branch_flag_i = ($urandom_range(99) < 15);
      branch_target_address_i = $urandom;
      imem_ack      = ($urandom_range(99) < 60);
      step();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc, m_pc); end
      checks++; if (ce !== m_ce) begin errors++; $display("FAIL rnd_ce@%0d: got %b want %b", i, ce, m_ce); end
      checks++; if (imem_req !== (m_ce && m_started && !m_parked)) begin
        errors++; $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, m_ce && m_started && !m_parked);
      end
      checks++; if (misalign_o !== m_mis) begin errors++; $display("FAIL rnd_mis@%0d: got %b want %b", i, misalign_o, m_mis); end
      checks++; if (fetch_count !== m_cnt) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, fetch_count, m_cnt); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch_hold();
    test_flush();
    test_misalign();
    test_wrap();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
